spi_cfg_programmer: RTL and testbench

//  Parametrised serial configuration programmer; successor to the fixed 64-bit DOGX programmer.

---
 rtl/spi_cfg_programmer.sv | 277 +++++++++++++++++++++++++++
 tb/tb_spi_cfg_programmer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_programmer.sv
// ============================================================================
//  Module   : spi_cfg_programmer
//  Purpose  : Serial (SPI mode 0) configuration programmer. Oversamples
//             SCLK/CS/SDI on the system clock, decodes a command byte plus
//             auto-incrementing data bytes into a shadow register file and
//             commits the shadow to the active image on a clean CS release.
//             Supports readback of the active image on SDO.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_cfg_programmer #(
  parameter int                      NUM_REGS    = 8,
  parameter int                      ADDR_W      = 7,
  parameter int                      SYNC_STAGES = 2,
  parameter logic [NUM_REGS*8-1:0]   RESET_IMAGE = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       SCLK,
  input  logic                       CS,
  input  logic                       SDI,
  output logic                       SDO,
  output logic                       SDO_OE,
  output logic [NUM_REGS*8-1:0]      cfg,
  output logic                       cfg_update,
  output logic                       frame_err
);

  // Register index width; a single register still needs one index bit.
  localparam int                 IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0]    c_NUM_REGS = (ADDR_W+1)'(NUM_REGS);
  localparam logic [IDX_W-1:0]   c_LAST_IDX = IDX_W'(NUM_REGS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  // Synchronisers and previous-sample registers for edge detection
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic                   r_sclk_prev;
  logic                   r_cs_prev;

  // Frame state
  logic [2:0]             r_state;
  logic [2:0]             w_state_nxt;
  logic [2:0]             r_bitcnt;
  logic [7:0]             r_shift;
  logic [IDX_W-1:0]       r_addr;
  logic                   r_wrote;
  logic                   r_sdo;
  logic                   r_cfg_update;
  logic                   r_frame_err;
  logic                   w_sdo_oe;

  // Active image and shadow copy
  logic [7:0]             r_cfg_mem [NUM_REGS];
  logic [7:0]             r_shadow  [NUM_REGS];

  // Decoded events
  logic                   w_sclk_s;
  logic                   w_cs_s;
  logic                   w_sdi_s;
  logic                   w_cs_rise;
  logic                   w_cs_fall;
  logic                   w_sclk_rise;
  logic                   w_sclk_fall;
  logic                   w_byte_done;
  logic [7:0]             w_byte_in;
  logic [ADDR_W-1:0]      w_cmd_addr;
  logic [IDX_W-1:0]       w_cmd_idx;
  logic                   w_addr_ok;
  logic [IDX_W-1:0]       w_next_idx;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_sdi_s     = r_sdi_sync[SYNC_STAGES-1];

  assign w_cs_rise   = ~r_cs_prev & w_cs_s;
  assign w_cs_fall   = r_cs_prev & ~w_cs_s;
  // A CS release seen in the same clock as an SCLK edge takes priority.
  assign w_sclk_rise = ~r_sclk_prev & w_sclk_s & ~w_cs_rise;
  assign w_sclk_fall = r_sclk_prev & ~w_sclk_s & ~w_cs_rise;

  assign w_byte_in   = {r_shift[6:0], w_sdi_s};
  assign w_byte_done = w_sclk_rise & (r_bitcnt == 3'd7);
  assign w_cmd_addr  = w_byte_in[ADDR_W-1:0];
  assign w_cmd_idx   = w_cmd_addr[IDX_W-1:0];
  assign w_addr_ok   = ({1'b0, w_cmd_addr} < c_NUM_REGS);
  assign w_next_idx  = (r_addr == c_LAST_IDX) ? '0 : r_addr + IDX_W'(1);

  // Bring the asynchronous serial pins into the clk domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_sdi_sync  <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS};
      r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], SDI};
      r_sclk_prev <= w_sclk_s;
      r_cs_prev   <= w_cs_s;
    end
  end

  // Frame state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: CS release always returns to idle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = S_CMD;
        end
      end
      S_CMD: begin
        if (w_cs_rise) begin
          w_state_nxt = S_IDLE;
        end else if (w_byte_done) begin
          if (!w_addr_ok) begin
            w_state_nxt = S_ERR;
          end else if (w_byte_in[7]) begin
            w_state_nxt = S_READ;
          end else begin
            w_state_nxt = S_WRITE;
          end
        end
      end
      S_WRITE, S_READ, S_ERR: begin
        if (w_cs_rise) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State-derived outputs: SDO is driven only while a readback is active
  always_comb begin
    w_sdo_oe = 1'b0;
    if (r_state == S_READ) begin
      w_sdo_oe = 1'b1;
    end
  end

  // Shift/count/address datapath, shadow writes and commit/abort on CS release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bitcnt     <= 3'd0;
      r_shift      <= 8'd0;
      r_addr       <= '0;
      r_wrote      <= 1'b0;
      r_sdo        <= 1'b0;
      r_cfg_update <= 1'b0;
      r_frame_err  <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
        r_cfg_mem[k] <= RESET_IMAGE[8*k +: 8];
        r_shadow[k]  <= RESET_IMAGE[8*k +: 8];
      end
    end else begin
      r_cfg_update <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_cs_rise && (r_state != S_IDLE)) begin
        r_bitcnt <= 3'd0;
        r_wrote  <= 1'b0;
        r_sdo    <= 1'b0;
        case (r_state)
          S_WRITE: begin
            if (r_bitcnt != 3'd0) begin
              // Partial byte: drop every byte of this frame
              r_frame_err <= 1'b1;
              for (int k = 0; k < NUM_REGS; k++) begin
                r_shadow[k] <= r_cfg_mem[k];
              end
            end else if (r_wrote) begin
              r_cfg_update <= 1'b1;
              for (int k = 0; k < NUM_REGS; k++) begin
                r_cfg_mem[k] <= r_shadow[k];
              end
            end
          end
          S_CMD: begin
            if (r_bitcnt != 3'd0) begin
              r_frame_err <= 1'b1;
            end
          end
          S_ERR: begin
            r_frame_err <= 1'b1;
            for (int k = 0; k < NUM_REGS; k++) begin
              r_shadow[k] <= r_cfg_mem[k];
            end
          end
          default: begin
          end
        endcase
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_cs_fall) begin
              r_bitcnt <= 3'd0;
              r_wrote  <= 1'b0;
            end
          end
          S_CMD: begin
            if (w_sclk_rise) begin
              r_shift  <= w_byte_in;
              r_bitcnt <= r_bitcnt + 3'd1;
              if (w_byte_done) begin
                r_addr <= w_cmd_idx;
                if (w_addr_ok && w_byte_in[7]) begin
                  r_shift <= r_cfg_mem[w_cmd_idx];
                end
              end
            end
          end
          S_WRITE: begin
            if (w_sclk_rise) begin
              r_shift  <= w_byte_in;
              r_bitcnt <= r_bitcnt + 3'd1;
              if (w_byte_done) begin
                r_shadow[r_addr] <= w_byte_in;
                r_addr           <= w_next_idx;
                r_wrote          <= 1'b1;
              end
            end
          end
          S_READ: begin
            // Present the next bit on the falling edge so it is stable at the master's rise
            if (w_sclk_fall) begin
              r_sdo    <= r_shift[7];
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                r_shift <= r_cfg_mem[w_next_idx];
                r_addr  <= w_next_idx;
              end else begin
                r_shift <= {r_shift[6:0], 1'b0};
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Flatten the active image, reg0 in the least significant byte
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
    assign cfg[8*g +: 8] = r_cfg_mem[g];
  end

  assign SDO        = r_sdo;
  assign SDO_OE     = w_sdo_oe;
  assign cfg_update = r_cfg_update;
  assign frame_err  = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_spi_cfg_programmer.sv
// ============================================================================
//  Module   : tb_spi_cfg_programmer
//  Purpose  : Self-checking bench for spi_cfg_programmer: directed frame
//             table, reset and mid-frame reset sequences, and random frames
//             checked against a byte-array model of the register file.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_cfg_programmer;

  localparam int          N       = 8;
  localparam logic [63:0] RST_IMG = 64'h8877_6655_4433_2211;
  localparam int          HALF    = 50;  // SCLK half period in ns (clk is 10 ns)

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        SCLK = 1'b0;
  logic        CS = 1'b1;
  logic        SDI = 1'b0;
  logic        SDO;
  logic        SDO_OE;
  logic [63:0] cfg;
  logic        cfg_update;
  logic        frame_err;

  int n_vec = 0;
  int n_mis = 0;
  int n_upd = 0;
  int n_err = 0;

  logic [7:0]  model_cfg [N];
  logic [79:0] rd_bits;
  bit          oe_lo_seen;
  bit          oe_hi_seen;

  typedef struct {
    int          ncmd;     // command bits sent (8 = full command byte)
    logic [7:0]  cmd;
    int          nbytes;   // full data bytes after the command
    logic [79:0] data;     // data byte b in data[8b+7:8b]
    int          extra;    // trailing partial-byte bits
    logic [7:0]  xval;
    int          exp_upd;
    int          exp_err;
  } vec_t;

  vec_t vt [13];

  spi_cfg_programmer #(
    .NUM_REGS    (N),
    .ADDR_W      (7),
    .SYNC_STAGES (2),
    .RESET_IMAGE (RST_IMG)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .SCLK       (SCLK),
    .CS         (CS),
    .SDI        (SDI),
    .SDO        (SDO),
    .SDO_OE     (SDO_OE),
    .cfg        (cfg),
    .cfg_update (cfg_update),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Count pulse cycles away from the active edge
  always @(negedge clk) begin
    if (cfg_update) n_upd++;
    if (frame_err)  n_err++;
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_img();
    logic [63:0] img;
    for (int k = 0; k < N; k++) img[8*k +: 8] = model_cfg[k];
    return img;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) model_cfg[k] = RST_IMG[8*k +: 8];
  endtask

  // Frame semantics from the register-file point of view
  task automatic model_frame(input vec_t v, output int e_upd, output int e_err,
                             output logic [79:0] e_rd);
    int a;
    e_upd = 0;
    e_err = 0;
    e_rd  = '0;
    if (v.ncmd < 8) begin
      e_err = (v.ncmd > 0) ? 1 : 0;
      return;
    end
    a = int'(v.cmd[6:0]);
    if (a >= N) begin
      e_err = 1;
      return;
    end
    if (v.cmd[7]) begin
      for (int b = 0; b < v.nbytes; b++) e_rd[8*b +: 8] = model_cfg[(a + b) % N];
      return;
    end
    if (v.extra > 0) begin
      e_err = 1;
      return;
    end
    if (v.nbytes > 0) begin
      for (int b = 0; b < v.nbytes; b++) model_cfg[(a + b) % N] = v.data[8*b +: 8];
      e_upd = 1;
    end
  endtask

  task automatic send_bit(input logic b, output logic s, output logic oe);
    SDI = b;
    #(HALF);
    SCLK = 1'b1;
    s  = SDO;
    oe = SDO_OE;
    #(HALF);
    SCLK = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input bit is_read);
    logic s, oe;
    rd_bits    = '0;
    oe_lo_seen = 1'b0;
    oe_hi_seen = 1'b0;
    CS = 1'b0;
    #(HALF);
    for (int i = 0; i < v.ncmd; i++) begin
      send_bit(v.cmd[7-i], s, oe);
      if (oe) oe_hi_seen = 1'b1;
    end
    if (v.ncmd == 8) begin
      for (int b = 0; b < v.nbytes; b++) begin
        for (int i = 0; i < 8; i++) begin
          send_bit(v.data[8*b + 7 - i], s, oe);
          rd_bits[8*b + 7 - i] = s;
          if (oe)  oe_hi_seen = 1'b1;
          if (!oe) oe_lo_seen = 1'b1;
        end
      end
      for (int i = 0; i < v.extra; i++) begin
        send_bit(v.xval[7-i], s, oe);
        if (oe) oe_hi_seen = 1'b1;
      end
    end
    #(HALF);
    CS = 1'b1;
    #(HALF * 4);
    if (is_read) begin
      // silence unused-path differences between read/write frames
    end
  endtask

  task automatic apply(input vec_t v, input bit use_tbl, input string tag);
    int          m_upd, m_err, u0, e0, e_upd, e_err, a;
    logic [79:0] m_rd;
    bit          valid_rd;
    model_frame(v, m_upd, m_err, m_rd);
    e_upd    = use_tbl ? v.exp_upd : m_upd;
    e_err    = use_tbl ? v.exp_err : m_err;
    a        = int'(v.cmd[6:0]);
    valid_rd = (v.ncmd == 8) && v.cmd[7] && (a < N);
    u0 = n_upd;
    e0 = n_err;
    run_frame(v, valid_rd);
    chk($sformatf("%s_cfg", tag), {16'h0, cfg}, {16'h0, model_img()});
    chk($sformatf("%s_upd", tag), 80'(n_upd - u0), 80'(e_upd));
    chk($sformatf("%s_err", tag), 80'(n_err - e0), 80'(e_err));
    chk($sformatf("%s_oe_after", tag), {79'h0, SDO_OE}, 80'h0);
    if (valid_rd) begin
      for (int b = 0; b < v.nbytes; b++)
        chk($sformatf("%s_rd%0d", tag, b), {72'h0, rd_bits[8*b +: 8]}, {72'h0, m_rd[8*b +: 8]});
      if (v.nbytes > 0) chk($sformatf("%s_oe_low_in_read", tag), {79'h0, oe_lo_seen}, 80'h0);
    end else begin
      chk($sformatf("%s_oe_high", tag), {79'h0, oe_hi_seen}, 80'h0);
    end
  endtask

  initial begin
    vec_t        v;
    logic [95:0] rnd;
    logic        s, oe;
    int          u0;

    // ncmd, cmd, nbytes, data, extra, xval, exp_upd, exp_err
    vt[0]  = '{8, 8'h00, 8, 80'h0000_A5A1_21B3_DAD9_BD05, 0, 8'h00, 1, 0}; // burst write
    vt[1]  = '{8, 8'h86, 2, 80'h0,                       0, 8'h00, 0, 0}; // readback A1,A5
    vt[2]  = '{8, 8'h02, 1, 80'hAA,                      3, 8'hE0, 0, 1}; // partial data byte
    vt[3]  = '{8, 8'h02, 1, 80'h5A,                      0, 8'h00, 1, 0}; // clean write after abort
    vt[4]  = '{8, 8'h07, 2, 80'h2211,                    0, 8'h00, 1, 0}; // wrap 7 -> 0
    vt[5]  = '{8, 8'h08, 1, 80'h33,                      0, 8'h00, 0, 1}; // out of range
    vt[6]  = '{5, 8'h01, 0, 80'h0,                       0, 8'h00, 0, 1}; // partial command
    vt[7]  = '{8, 8'h03, 0, 80'h0,                       0, 8'h00, 0, 0}; // command only
    vt[8]  = '{8, 8'h05, 9, 80'h00C9_C8C7_C6C5_C4C3_C2C1, 0, 8'h00, 1, 0}; // wrap overwrite
    vt[9]  = '{8, 8'h87, 3, 80'h0,                       0, 8'h00, 0, 0}; // read wraps
    vt[10] = '{8, 8'hFF, 1, 80'h0,                       0, 8'h00, 0, 1}; // read out of range
    vt[11] = '{8, 8'h81, 1, 80'h0,                       4, 8'hF0, 0, 0}; // read with partial
    vt[12] = '{0, 8'h00, 0, 80'h0,                       0, 8'h00, 0, 0}; // CS blip, no clocks

    // Reset held
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_cfg", {16'h0, cfg}, {16'h0, RST_IMG});
    chk("rst_oe", {79'h0, SDO_OE}, 80'h0);
    chk("rst_sdo", {79'h0, SDO}, 80'h0);
    chk("rst_pulses", {78'h0, cfg_update, frame_err}, 80'h0);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_pulses", 80'(n_upd + n_err), 80'h0);
    chk("post_rst_cfg", {16'h0, cfg}, {16'h0, RST_IMG});
    model_reset();

    // Directed table
    for (int i = 0; i < 13; i++) begin
      apply(vt[i], 1'b1, $sformatf("vec%0d", i));
      if (i == 0) chk("t2_cfg_const", {16'h0, cfg}, {16'h0, 64'hA5A1_21B3_DAD9_BD05});
      if (i == 1) chk("t4_rd_const", {64'h0, rd_bits[15:0]}, {64'h0, 16'hA5A1});
      if (i == 4) chk("t5_reg7_reg0", {64'h0, cfg[63:56], cfg[7:0]}, {64'h0, 16'h1122});
    end

    // Reset in the middle of a write frame
    u0 = n_upd;
    CS = 1'b0;
    #(HALF);
    for (int i = 0; i < 8; i++) send_bit(1'b0, s, oe);
    for (int i = 0; i < 32; i++) send_bit(1'($urandom_range(0, 1)), s, oe);
    #(HALF / 2);
    reset = 1'b0;
    #1;
    chk("midrst_cfg", {16'h0, cfg}, {16'h0, RST_IMG});
    chk("midrst_oe", {79'h0, SDO_OE}, 80'h0);
    #(HALF);
    CS = 1'b1;
    #(HALF * 2);
    reset = 1'b1;
    #(HALF * 4);
    chk("midrst_no_update", 80'(n_upd - u0), 80'h0);
    chk("midrst_cfg_after", {16'h0, cfg}, {16'h0, RST_IMG});
    model_reset();
    v = '{8, 8'h01, 2, 80'hBEEF, 0, 8'h00, 1, 0};
    apply(v, 1'b1, "midrst_next_wr");
    v = '{8, 8'h81, 2, 80'h0, 0, 8'h00, 0, 0};
    apply(v, 1'b1, "midrst_next_rd");

    // Random frames against the model
    for (int r = 0; r < 24; r++) begin
      rnd      = {$urandom, $urandom, $urandom};
      v.ncmd   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : 8;
      v.cmd    = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 9))};
      v.nbytes = int'($urandom_range(0, 9));
      v.data   = rnd[79:0];
      v.extra  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      v.xval   = 8'($urandom);
      v.exp_upd = 0;
      v.exp_err = 0;
      apply(v, 1'b0, $sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
